// File: rtl/muldiv_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq_pkg
// Purpose  : Shared types and constants for the RV32M multiply/divide
//            sequencer: ALU op codes, sequencer state encoding and small
//            op-class helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_seq_pkg;

  // Decoder op codes. The M-extension ops occupy one contiguous range so a
  // simple range compare classifies them.
  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;

  typedef enum logic [1:0] {
    MDS_IDLE = 2'd0,
    MDS_PREP = 2'd1,
    MDS_CALC = 2'd2,
    MDS_FIN  = 2'd3
  } mds_state_t;

  function automatic logic is_m_op(input logic [4:0] op);
    return (op >= ALU_MUL) && (op <= ALU_REMU);
  endfunction

  // Only meaningful for ops already known to be M-extension ops.
  function automatic logic is_div_op(input logic [4:0] op);
    return (op >= ALU_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq_if
// Purpose  : Request/response bundle between execute and the mul/div
//            sequencer.
// Ports    : master - execute side (drives start/op/operands/rd/flush)
//            slave  - sequencer side (drives busy/stall/done/result/rd)
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [4:0]      alu_op;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_in;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      result_rd;

  modport master (
    output start, alu_op, rs1_val, rs2_val, rd_in, flush,
    input  busy, stall, done, result, result_rd
  );

  modport slave (
    input  start, alu_op, rs1_val, rs2_val, rd_in, flush,
    output busy, stall, done, result, result_rd
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_seq_div_step.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq_div_step
// Purpose  : One combinational restoring-division step. Shifts the next
//            dividend bit (MSB of the quotient shift register) into the
//            partial remainder, trial-subtracts the divisor and keeps the
//            difference unless it borrowed.
// Ports    : rem_in/quot_in/divisor -> rem_out/quot_out
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quot_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quot_out
);
  // Partial remainder is one bit wider so the borrow of the trial subtract
  // lands in the MSB.
  logic [XLEN:0] w_shifted;
  logic [XLEN:0] w_diff;
  logic          w_borrow;

  assign w_shifted = {rem_in, quot_in[XLEN-1]};
  assign w_diff    = w_shifted - {1'b0, divisor};
  assign w_borrow  = w_diff[XLEN];

  assign rem_out  = w_borrow ? w_shifted[XLEN-1:0] : w_diff[XLEN-1:0];
  assign quot_out = {quot_in[XLEN-2:0], ~w_borrow};
endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Purpose  : Multi-cycle RV32M sequencer. Accepts one MUL/MULH/MULHSU/MULHU/
//            DIV/DIVU/REM/REMU op, runs XLEN shift-add or restoring-divide
//            iterations on operand magnitudes, sign-fixes the result and
//            returns it tagged with its destination register.
// Ports    : clock, reset (async, active high)
//            bus (slave) : start, alu_op, rs1_val, rs2_val, rd_in, flush in;
//                          busy, stall, done, result, result_rd out
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic          clock,
  input  logic          reset,
  muldiv_seq_if.slave   bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] C_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  mds_state_t        r_state;
  mds_state_t        w_state_next;

  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_result_rd;
  logic [CW-1:0]     r_count;
  logic [4:0]        r_op;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_a;         // rs1, then |rs1|, then quotient shift reg
  logic [XLEN-1:0]   r_b;         // rs2, then |rs2|
  logic [2*XLEN-1:0] r_acc;       // product accumulator, multiplier in low half
  logic [XLEN-1:0]   r_rem;       // partial remainder
  logic              r_neg;       // final result must be negated
  logic              r_special;   // div-by-zero or signed overflow
  logic [XLEN-1:0]   r_spec_val;

  logic              w_accept;
  logic              w_fin_done;
  logic              w_is_div;
  logic              w_is_rem;
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_abs;
  logic [XLEN-1:0]   w_b_abs;
  logic              w_neg_res;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_spec_val;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_acc_next;
  logic [XLEN-1:0]   w_rem_next;
  logic [XLEN-1:0]   w_quot_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_final;

  // flush outranks start, so a flushed cycle never accepts.
  assign w_accept   = bus.start & ~r_busy & is_m_op(bus.alu_op) & ~bus.flush;
  assign w_fin_done = (r_state == MDS_FIN) & ~bus.flush;

  // --------------------------------------------------------------------------
  // Operand classification (valid from PREP onwards, r_op is latched)
  // --------------------------------------------------------------------------
  assign w_is_div   = is_div_op(r_op);
  assign w_is_rem   = (r_op == ALU_REM) | (r_op == ALU_REMU);
  assign w_a_signed = (r_op == ALU_MUL) | (r_op == ALU_MULH) | (r_op == ALU_MULHSU) |
                      (r_op == ALU_DIV) | (r_op == ALU_REM);
  assign w_b_signed = (r_op == ALU_MUL) | (r_op == ALU_MULH) |
                      (r_op == ALU_DIV) | (r_op == ALU_REM);
  assign w_a_neg    = w_a_signed & r_a[XLEN-1];
  assign w_b_neg    = w_b_signed & r_b[XLEN-1];
  assign w_a_abs    = w_a_neg ? -r_a : r_a;
  assign w_b_abs    = w_b_neg ? -r_b : r_b;
  // Remainder follows the dividend; everything else is the sign product.
  assign w_neg_res  = w_is_rem ? w_a_neg : (w_a_neg ^ w_b_neg);

  assign w_div_zero = w_is_div & (r_b == '0);
  assign w_div_ovf  = ((r_op == ALU_DIV) | (r_op == ALU_REM)) &
                      (r_a == C_INT_MIN) & (r_b == '1);
  assign w_special  = w_div_zero | w_div_ovf;
  assign w_spec_val = w_div_zero ? (w_is_rem ? r_a : '1)
                                 : (w_is_rem ? '0  : r_a);

  // --------------------------------------------------------------------------
  // Iteration datapath
  // --------------------------------------------------------------------------
  // Shift-add: add multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right with carry.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_acc_next = {w_mul_sum, r_acc[XLEN-1:1]};

  muldiv_seq_div_step #(
    .XLEN (XLEN)
  ) u_div_step (
    .rem_in   (r_rem),
    .quot_in  (r_a),
    .divisor  (r_b),
    .rem_out  (w_rem_next),
    .quot_out (w_quot_next)
  );

  // --------------------------------------------------------------------------
  // Sign fix and result select
  // --------------------------------------------------------------------------
  assign w_prod     = r_neg ? -r_acc : r_acc;
  assign w_quot_fix = r_neg ? -r_a   : r_a;
  assign w_rem_fix  = r_neg ? -r_rem : r_rem;

  always_comb begin
    w_final = '0;
    if (r_special) begin
      w_final = r_spec_val;
    end else if (w_is_div) begin
      w_final = w_is_rem ? w_rem_fix : w_quot_fix;
    end else if (r_op == ALU_MUL) begin
      w_final = w_prod[XLEN-1:0];
    end else begin
      w_final = w_prod[2*XLEN-1:XLEN];
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= MDS_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      MDS_IDLE: if (w_accept) w_state_next = MDS_PREP;
      MDS_PREP: w_state_next = w_special ? MDS_FIN : MDS_CALC;
      MDS_CALC: if (r_count == CW'(XLEN-1)) w_state_next = MDS_FIN;
      MDS_FIN:  w_state_next = MDS_IDLE;
      default:  w_state_next = MDS_IDLE;
    endcase
    if (bus.flush && (r_state != MDS_IDLE)) begin
      w_state_next = MDS_IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_result_rd <= '0;
      r_count     <= '0;
      r_op        <= '0;
      r_rd        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_rem       <= '0;
      r_neg       <= 1'b0;
      r_special   <= 1'b0;
      r_spec_val  <= '0;
    end else begin
      r_busy <= (w_state_next != MDS_IDLE);
      r_done <= w_fin_done;
      case (r_state)
        MDS_IDLE: begin
          if (w_accept) begin
            r_op <= bus.alu_op;
            r_a  <= bus.rs1_val;
            r_b  <= bus.rs2_val;
            r_rd <= bus.rd_in;
          end
        end
        MDS_PREP: begin
          r_a        <= w_a_abs;
          r_b        <= w_b_abs;
          r_acc      <= {{XLEN{1'b0}}, w_b_abs};
          r_rem      <= '0;
          r_neg      <= w_neg_res;
          r_special  <= w_special;
          r_spec_val <= w_spec_val;
          r_count    <= '0;
        end
        MDS_CALC: begin
          r_count <= r_count + CW'(1);
          if (w_is_div) begin
            r_rem <= w_rem_next;
            r_a   <= w_quot_next;
          end else begin
            r_acc <= w_acc_next;
          end
        end
        MDS_FIN: begin
          if (!bus.flush) begin
            r_result    <= w_final;
            r_result_rd <= r_rd;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.stall     = r_busy | (bus.start & is_m_op(bus.alu_op));
  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.result_rd = r_result_rd;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_seq
// Purpose  : Self-checking bench for muldiv_seq: vector table of ops with
//            expected result and latency, scoreboard queue popped on done,
//            plus hand-written flush / reset / ignore / back-to-back cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  localparam int XLEN = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  muldiv_seq_if #(.XLEN(XLEN)) bus();

  muldiv_seq #(.XLEN(XLEN)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          due;
  } exp_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard: every done must match the oldest outstanding expectation.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("done_without_request", {31'b0, bus.done}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("result", bus.result, e.res);
        check("result_rd", {27'b0, bus.result_rd}, {27'b0, e.rd});
        check("latency_cycle", cyc, e.due);
        check("busy_in_done", {31'b0, bus.busy}, 32'd0);
      end
    end
  end

  // Called at a negedge: present a request for one cycle (caller clears).
  task automatic drive_op(input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
    bus.start   = 1'b1;
    bus.alu_op  = op;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.rd_in   = rd;
  endtask

  task automatic push_exp(input logic [31:0] res, input logic [4:0] rd, input int lat);
    sb.push_back('{res: res, rd: rd, due: cyc + lat});
  endtask

  // Wait (bounded) for the scoreboard to empty, watching stall meanwhile.
  task automatic wait_drain(input logic stall_ok_in);
    int   n;
    logic stall_ok;
    n = 0;
    stall_ok = stall_ok_in;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
      if (sb.size() != 0 && bus.stall !== 1'b1) stall_ok = 1'b0;
    end
    check("pending_after_wait", sb.size(), 32'd0);
    sb.delete();
    check("stall_held_until_done", {31'b0, stall_ok}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    logic stall_ok;
    @(negedge clock);
    drive_op(v.op, v.a, v.b, v.rd);
    push_exp(v.exp, v.rd, v.lat);
    #1;
    stall_ok = (bus.stall === 1'b1);
    @(negedge clock);
    bus.start = 1'b0;
    wait_drain(stall_ok);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    vecs = '{
      '{ALU_MUL,    32'h00000007, 32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 35},
      '{ALU_MULH,   32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 35},
      '{ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, 35},
      '{ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, 35},
      '{ALU_DIV,    32'hFFFFFFF9, 32'h00000002, 5'd5,  32'hFFFFFFFD, 35},
      '{ALU_REM,    32'hFFFFFFF9, 32'h00000002, 5'd6,  32'hFFFFFFFF, 35},
      '{ALU_DIVU,   32'd100,      32'd7,        5'd7,  32'd14,       35},
      '{ALU_REMU,   32'd100,      32'd7,        5'd8,  32'd2,        35},
      '{ALU_DIV,    32'd5,        32'd0,        5'd9,  32'hFFFFFFFF, 3},
      '{ALU_REMU,   32'd5,        32'd0,        5'd10, 32'd5,        3},
      '{ALU_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 3},
      '{ALU_REM,    32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h00000000, 3},
      '{ALU_MUL,    32'hFFFFFFFB, 32'hFFFFFFFA, 5'd13, 32'd30,       35},
      '{ALU_REM,    32'd7,        32'hFFFFFFFE, 5'd14, 32'd1,        35},
      '{ALU_DIVU,   32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0,        35},
      '{ALU_MULHU,  32'hFFFFFFFF, 32'd2,        5'd16, 32'd1,        35},
      '{ALU_DIVU,   32'd5,        32'd0,        5'd17, 32'hFFFFFFFF, 3},
      '{ALU_REM,    32'hFFFFFFF9, 32'd0,        5'd18, 32'hFFFFFFF9, 3},
      '{ALU_MULHSU, 32'h80000000, 32'd2,        5'd19, 32'hFFFFFFFF, 35}
    };

    bus.start = 1'b0; bus.alu_op = '0; bus.rs1_val = '0; bus.rs2_val = '0;
    bus.rd_in = '0;   bus.flush = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset_busy",      {31'b0, bus.busy},       32'd0);
    check("reset_done",      {31'b0, bus.done},       32'd0);
    check("reset_stall",     {31'b0, bus.stall},      32'd0);
    check("reset_result",    bus.result,              32'd0);
    check("reset_result_rd", {27'b0, bus.result_rd},  32'd0);

    for (int i = 0; i < 19; i++) run_vec(vecs[i]);

    // Flush in cycle 10 of a DIVU: no done, idle next cycle, then recover.
    @(negedge clock);
    drive_op(ALU_DIVU, 32'd1000, 32'd3, 5'd20);
    a0 = cyc;
    @(negedge clock);
    bus.start = 1'b0;
    while (cyc < a0 + 10) @(negedge clock);
    check("busy_before_flush", {31'b0, bus.busy}, 32'd1);
    bus.flush = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    check("busy_after_flush", {31'b0, bus.busy}, 32'd0);
    repeat (45) @(negedge clock);
    run_vec('{ALU_MUL, 32'd3, 32'd4, 5'd21, 32'd12, 35});

    // Async reset in cycle 20 of an op: outputs clear without a clock edge.
    @(negedge clock);
    drive_op(ALU_MUL, 32'h1234, 32'h5678, 5'd22);
    a0 = cyc;
    @(negedge clock);
    bus.start = 1'b0;
    while (cyc < a0 + 20) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("midop_reset_busy",      {31'b0, bus.busy},      32'd0);
    check("midop_reset_result",    bus.result,             32'd0);
    check("midop_reset_result_rd", {27'b0, bus.result_rd}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (45) @(negedge clock);
    check("idle_after_reset", {31'b0, bus.busy}, 32'd0);

    // Non-M op is ignored.
    @(negedge clock);
    drive_op(ALU_ADD, 32'd1, 32'd2, 5'd23);
    #1 check("stall_non_m_op", {31'b0, bus.stall}, 32'd0);
    @(negedge clock);
    bus.start = 1'b0;
    check("busy_after_non_m_op", {31'b0, bus.busy}, 32'd0);
    repeat (5) @(negedge clock);

    // start while busy is ignored: only the first op completes.
    @(negedge clock);
    drive_op(ALU_DIVU, 32'd100, 32'd7, 5'd5);
    push_exp(32'd14, 5'd5, 35);
    @(negedge clock);
    bus.start = 1'b0;
    repeat (5) @(negedge clock);
    drive_op(ALU_DIV, 32'd50, 32'd5, 5'd9);
    @(negedge clock);
    bus.start = 1'b0;
    wait_drain(1'b1);

    // Back-to-back: accept a new op in the done cycle; rd 5 then 9.
    @(negedge clock);
    drive_op(ALU_MUL, 32'd6, 32'd7, 5'd5);
    push_exp(32'd42, 5'd5, 35);
    @(negedge clock);
    bus.start = 1'b0;
    for (int n = 0; n < 60 && sb.size() != 0; n++) @(negedge clock);
    check("done_in_b2b_cycle", {31'b0, bus.done}, 32'd1);
    drive_op(ALU_REMU, 32'd100, 32'd7, 5'd9);
    push_exp(32'd2, 5'd9, 35);
    @(negedge clock);
    bus.start = 1'b0;
    wait_drain(1'b1);

    repeat (5) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
